// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types for the memory fill controller: FSM state encoding, the
// write-buffer entry layout and the default write-buffer depth.
//
// Write-buffer entries hold a word address (byte address >> 2) and the store
// data. Field widths are sized for the default 32-bit address/data build;
// narrower module parameters are zero-extended into the entry and truncated
// back out of it.
//
// Optional build macro used by the files importing this package: WB_FWD_EN.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WB_DEPTH_DEF = 4;
    localparam int WB_ADDR_MAX  = 32;
    localparam int WB_WADDR_W   = WB_ADDR_MAX - 2;
    localparam int WB_DATA_W    = 32;

    // Explicit encodings keep the state vector identical to the legacy
    // two-bit constants used by existing debug scripts.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_READ  = 2'd2,
        ST_RESP  = 2'd3
    } fill_state_e;

    typedef struct packed {
        logic [WB_WADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0]  data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Posted-store FIFO for the memory fill controller. DEPTH entries of
// wb_entry_t, pointers wrap modulo DEPTH (DEPTH is a power of two), occupancy
// is tracked as an explicit count so full and empty are unambiguous.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (clears all entries)
//   push         enqueue push_entry (ignored while full)
//   push_entry   entry to enqueue
//   pop          dequeue the head (ignored while empty)
//   head         oldest entry
//   head_nxt     entry behind the head (valid only when count >= 2)
//   full, empty  occupancy flags
//   count        number of valid entries, 0..DEPTH
//   entries      (WB_FWD_EN only) raw storage, for forwarding lookups
//   rd_ptr       (WB_FWD_EN only) storage index of the head
// -----------------------------------------------------------------------------
module wb_fifo
    import mem_pkg::*;
#(
    parameter  int DEPTH = WB_DEPTH_DEF,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  wb_entry_t              push_entry,
    input  logic                   pop,
    output wb_entry_t              head,
    output wb_entry_t              head_nxt,
    output logic                   full,
    output logic                   empty,
    output logic [CW-1:0]          count
`ifdef WB_FWD_EN
    ,
    output wb_entry_t [DEPTH-1:0]  entries,
    output logic [PW-1:0]          rd_ptr
`endif
);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_do_push;
    logic                  w_do_pop;
    logic [PW-1:0]         w_rd_ptr_nxt;

    assign full         = (r_count == CW'(DEPTH));
    assign empty        = (r_count == '0);
    assign count        = r_count;

    // A full buffer refuses the push even when a pop happens in the same cycle.
    assign w_do_push    = push & ~full;
    assign w_do_pop     = pop & ~empty;

    assign w_rd_ptr_nxt = r_rd_ptr + PW'(1);
    assign head         = r_mem[r_rd_ptr];
    assign head_nxt     = r_mem[w_rd_ptr_nxt];

`ifdef WB_FWD_EN
    assign entries      = r_mem;
    assign rd_ptr       = r_rd_ptr;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_entry;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mem_fill_ctrl.sv
// -----------------------------------------------------------------------------
// mem_fill_ctrl
// Cache-side memory controller: posts stores into a write buffer, drains the
// buffer to main memory, and services read misses with a one-word refill.
// Reads are strictly ordered behind every store accepted before them.
//
// Build macro: WB_FWD_EN -- when defined, a read accepted in IDLE whose word
// address hits a buffered store is answered from the youngest matching entry
// without touching memory. Undefined: no address comparison at all.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   req_valid/req_write/req_addr/
//   req_wdata/req_ready               cache request handshake (store or miss)
//   fill_valid/fill_data              one-cycle refill word
//   mem_req/mem_we/mem_addr/mem_wdata main-memory request (all registered)
//   mem_ready/mem_rdata               main-memory completion and read data
//
// state  | meaning
// IDLE   | nothing in flight; accept reads, start draining posted stores
// DRAIN  | writing buffer head to memory; a latched read waits behind it
// READ   | read miss issued to memory, waiting for mem_ready
// RESP   | fill_valid pulse with the captured refill word
// -----------------------------------------------------------------------------
module mem_fill_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int WB_DEPTH   = WB_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  fill_valid,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    fill_state_e           r_state;
    logic                  r_rd_pend;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_fill_valid;
    logic [DATA_WIDTH-1:0] r_fill_data;

    logic                  w_is_idle;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_rd_acc;
    logic                  w_last_pop;
    logic [ADDR_WIDTH-1:0] w_req_waddr;
    wb_entry_t             w_push_entry;
    wb_entry_t             w_head;
    wb_entry_t             w_head_nxt;
    wb_entry_t             w_next_entry;
    logic                  w_full;
    logic                  w_empty;
    logic [CW-1:0]         w_count;
    logic                  w_unused_addr_lsb;

    function automatic logic [ADDR_WIDTH-1:0] f_byte_addr(input logic [WB_WADDR_W-1:0] waddr);
        return {(ADDR_WIDTH-2)'(waddr), 2'b00};
    endfunction

    // Byte-lane bits of the request address carry no meaning here.
    assign w_unused_addr_lsb   = ^req_addr[1:0];

    assign w_is_idle           = (r_state == ST_IDLE);
    assign w_push              = req_valid & req_write & ~w_full;
    assign w_rd_acc            = req_valid & ~req_write & w_is_idle;
    assign w_pop               = (r_state == ST_DRAIN) & r_mem_req & mem_ready;
    assign req_ready           = req_write ? ~w_full : w_is_idle;

    assign w_req_waddr         = {req_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_push_entry.addr   = WB_WADDR_W'(req_addr[ADDR_WIDTH-1:2]);
    assign w_push_entry.data   = WB_DATA_W'(req_wdata);

    // The popped head was the last entry unless a store lands this same cycle.
    assign w_last_pop          = (w_count == CW'(1)) & ~w_push;
    // Entry presented after a pop: the one behind the head, or, when the head
    // was alone, the store being pushed right now.
    assign w_next_entry        = (w_count == CW'(1)) ? w_push_entry : w_head_nxt;

`ifdef WB_FWD_EN
    wb_entry_t [WB_DEPTH-1:0] w_entries;
    logic [PW-1:0]            w_rd_ptr;
    logic                     w_fwd_hit;
    logic [WB_DATA_W-1:0]     w_fwd_data;

    // Walk from oldest to youngest valid entry; later hits overwrite earlier
    // ones so the youngest matching store wins.
    always_comb begin
        w_fwd_hit  = 1'b0;
        w_fwd_data = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            if (CW'(k) < w_count) begin
                if (w_entries[w_rd_ptr + PW'(k)].addr == w_push_entry.addr) begin
                    w_fwd_hit  = 1'b1;
                    w_fwd_data = w_entries[w_rd_ptr + PW'(k)].data;
                end
            end
        end
    end
`endif

    wb_fifo #(
        .DEPTH      (WB_DEPTH)
    ) u_wb_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .head_nxt   (w_head_nxt),
        .full       (w_full),
        .empty      (w_empty),
        .count      (w_count)
`ifdef WB_FWD_EN
        ,
        .entries    (w_entries),
        .rd_ptr     (w_rd_ptr)
`endif
    );

    // All memory-side outputs are loaded together on the edge that starts a
    // transfer and are left untouched until mem_ready completes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_rd_pend    <= 1'b0;
            r_rd_addr    <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_fill_valid <= 1'b0;
            r_fill_data  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_rd_acc) begin
`ifdef WB_FWD_EN
                        if (w_fwd_hit) begin
                            r_state      <= ST_RESP;
                            r_fill_valid <= 1'b1;
                            r_fill_data  <= DATA_WIDTH'(w_fwd_data);
                        end else
`endif
                        if (w_empty) begin
                            r_state    <= ST_READ;
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_req_waddr;
                        end else begin
                            r_state     <= ST_DRAIN;
                            r_rd_pend   <= 1'b1;
                            r_rd_addr   <= w_req_waddr;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= f_byte_addr(w_head.addr);
                            r_mem_wdata <= DATA_WIDTH'(w_head.data);
                        end
                    end else if (!w_empty) begin
                        r_state     <= ST_DRAIN;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= f_byte_addr(w_head.addr);
                        r_mem_wdata <= DATA_WIDTH'(w_head.data);
                    end
                end

                ST_DRAIN: begin
                    if (w_pop) begin
                        if (w_last_pop) begin
                            if (r_rd_pend) begin
                                r_state    <= ST_READ;
                                r_mem_req  <= 1'b1;
                                r_mem_we   <= 1'b0;
                                r_mem_addr <= r_rd_addr;
                            end else begin
                                r_state   <= ST_IDLE;
                                r_mem_req <= 1'b0;
                                r_mem_we  <= 1'b0;
                            end
                        end else begin
                            r_mem_addr  <= f_byte_addr(w_next_entry.addr);
                            r_mem_wdata <= DATA_WIDTH'(w_next_entry.data);
                        end
                    end
                end

                ST_READ: begin
                    if (mem_ready) begin
                        r_state      <= ST_RESP;
                        r_rd_pend    <= 1'b0;
                        r_mem_req    <= 1'b0;
                        r_mem_we     <= 1'b0;
                        r_fill_valid <= 1'b1;
                        r_fill_data  <= mem_rdata;
                    end
                end

                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_fill_valid <= 1'b0;
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_mem_req    <= 1'b0;
                    r_fill_valid <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign fill_valid = r_fill_valid;
    assign fill_data  = r_fill_data;

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_fill_ctrl
// Directed bench for mem_fill_ctrl (32-bit address/data, 4-entry buffer).
// A per-cycle vector table covers a read miss, store-then-read ordering and
// buffer-full back-pressure; hand-written sequences cover forwarding (or its
// absence when WB_FWD_EN is undefined) and asynchronous reset mid-transfer.
// Inputs change 1 ns after the rising edge, outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_mem_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        req_ready;
    logic        fill_valid;
    logic [31:0] fill_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_fill_ctrl #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .WB_DEPTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        rv, rw;
        logic [31:0] ra, rd;
        logic        mr;
        logic [31:0] mrd;
        logic        e_rr, e_req, e_we;
        logic [31:0] e_addr, e_wd;
        logic        e_fv;
        logic [31:0] e_fd;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rv, rw, input logic [31:0] ra, rd,
                                input logic mr, input logic [31:0] mrd,
                                input logic e_rr, e_req, e_we,
                                input logic [31:0] e_addr, e_wd,
                                input logic e_fv, input logic [31:0] e_fd);
        vec_t v;
        v.rv = rv; v.rw = rw; v.ra = ra; v.rd = rd; v.mr = mr; v.mrd = mrd;
        v.e_rr = e_rr; v.e_req = e_req; v.e_we = e_we;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_fv = e_fv; v.e_fd = e_fd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic e_rr, e_req, e_we,
                           input logic [31:0] e_addr, e_wd,
                           input logic e_fv, input logic [31:0] e_fd);
        chk({nm, ".req_ready"},  {31'd0, req_ready},  {31'd0, e_rr});
        chk({nm, ".mem_req"},    {31'd0, mem_req},    {31'd0, e_req});
        chk({nm, ".mem_we"},     {31'd0, mem_we},     {31'd0, e_we});
        chk({nm, ".mem_addr"},   mem_addr,            e_addr);
        chk({nm, ".mem_wdata"},  mem_wdata,           e_wd);
        chk({nm, ".fill_valid"}, {31'd0, fill_valid}, {31'd0, e_fv});
        chk({nm, ".fill_data"},  fill_data,           e_fd);
    endtask

    // One clock cycle: drive inputs just after the rising edge, return on the
    // falling edge so the caller samples settled outputs.
    task automatic cyc(input logic rv, rw, input logic [31:0] ra, rd,
                       input logic mr, input logic [31:0] mrd);
        @(posedge clk);
        #1;
        req_valid = rv; req_write = rw; req_addr = ra; req_wdata = rd;
        mem_ready = mr; mem_rdata = mrd;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // read miss 0x104, mem_ready on the third cycle of the request
        vecs[0]  = mk(1,0,32'h104,0,            0,0,            1, 0,0,32'h000,0,     0,0);
        vecs[1]  = mk(0,0,0,0,                  0,0,            0, 1,0,32'h104,0,     0,0);
        vecs[2]  = mk(0,0,0,0,                  0,0,            0, 1,0,32'h104,0,     0,0);
        vecs[3]  = mk(0,0,0,0,                  1,32'hDEADBEEF, 0, 1,0,32'h104,0,     0,0);
        vecs[4]  = mk(0,0,0,0,                  0,0,            0, 0,0,32'h104,0,     1,32'hDEADBEEF);
        // store 0x200, then read 0x204: write must finish before read issues
        vecs[5]  = mk(1,1,32'h200,32'h11,       0,0,            1, 0,0,32'h104,0,     0,32'hDEADBEEF);
        vecs[6]  = mk(1,0,32'h204,0,            0,0,            1, 0,0,32'h104,0,     0,32'hDEADBEEF);
        vecs[7]  = mk(0,0,0,0,                  0,0,            0, 1,1,32'h200,32'h11,0,32'hDEADBEEF);
        vecs[8]  = mk(0,0,0,0,                  1,0,            0, 1,1,32'h200,32'h11,0,32'hDEADBEEF);
        vecs[9]  = mk(0,0,0,0,                  0,0,            0, 1,0,32'h204,32'h11,0,32'hDEADBEEF);
        vecs[10] = mk(0,0,0,0,                  1,32'h12345678, 0, 1,0,32'h204,32'h11,0,32'hDEADBEEF);
        vecs[11] = mk(0,0,0,0,                  0,0,            0, 0,0,32'h204,32'h11,1,32'h12345678);
        // five stores against a 4-entry buffer with memory stalled
        vecs[12] = mk(1,1,32'h400,32'h1,        0,0,            1, 0,0,32'h204,32'h11,0,32'h12345678);
        vecs[13] = mk(1,1,32'h404,32'h2,        0,0,            1, 0,0,32'h204,32'h11,0,32'h12345678);
        vecs[14] = mk(1,1,32'h408,32'h3,        0,0,            1, 1,1,32'h400,32'h1, 0,32'h12345678);
        vecs[15] = mk(1,1,32'h40C,32'h4,        0,0,            1, 1,1,32'h400,32'h1, 0,32'h12345678);
        vecs[16] = mk(1,1,32'h410,32'h5,        0,0,            0, 1,1,32'h400,32'h1, 0,32'h12345678);
        vecs[17] = mk(1,1,32'h410,32'h5,        1,0,            0, 1,1,32'h400,32'h1, 0,32'h12345678);
        vecs[18] = mk(1,1,32'h410,32'h5,        0,0,            1, 1,1,32'h404,32'h2, 0,32'h12345678);
        vecs[19] = mk(0,0,0,0,                  1,0,            0, 1,1,32'h404,32'h2, 0,32'h12345678);
        vecs[20] = mk(0,0,0,0,                  1,0,            0, 1,1,32'h408,32'h3, 0,32'h12345678);
        vecs[21] = mk(0,0,0,0,                  1,0,            0, 1,1,32'h40C,32'h4, 0,32'h12345678);
        vecs[22] = mk(0,0,0,0,                  1,0,            0, 1,1,32'h410,32'h5, 0,32'h12345678);
        vecs[23] = mk(0,0,0,0,                  0,0,            1, 0,0,32'h410,32'h5, 0,32'h12345678);

        // reset state
        repeat (2) @(negedge clk);
        chk_all("rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        req_write = 1'b1;
        #1;
        chk("rst.req_ready_store", {31'd0, req_ready}, 32'd1);
        req_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].rv, vecs[i].rw, vecs[i].ra, vecs[i].rd, vecs[i].mr, vecs[i].mrd);
            chk_all($sformatf("v%0d", i), vecs[i].e_rr, vecs[i].e_req, vecs[i].e_we,
                    vecs[i].e_addr, vecs[i].e_wd, vecs[i].e_fv, vecs[i].e_fd);
        end

        // stores posted while a read is outstanding, then read 0x302 in IDLE
        cyc(1,0,32'h500,0,         0,0);
        chk("fw.rd_ready", {31'd0, req_ready}, 32'd1);
        cyc(1,1,32'h300,32'hA,     0,0);
        chk("fw.st0_ready", {31'd0, req_ready}, 32'd1);
        chk("fw.rd_addr", mem_addr, 32'h500);
        cyc(1,1,32'h300,32'hB,     0,0);
        chk("fw.st1_ready", {31'd0, req_ready}, 32'd1);
        cyc(0,0,0,0,               1,32'h55);
        chk("fw.rd_req", {31'd0, mem_req}, 32'd1);
        cyc(0,0,0,0,               0,0);
        chk("fw.rd_fv", {31'd0, fill_valid}, 32'd1);
        chk("fw.rd_fd", fill_data, 32'h55);
        cyc(1,0,32'h302,0,         0,0);
        chk("fw.hit_ready", {31'd0, req_ready}, 32'd1);
        chk("fw.hit_fv0", {31'd0, fill_valid}, 32'd0);
        cyc(0,0,0,0,               0,0);
`ifdef WB_FWD_EN
        chk("fw.hit_fv", {31'd0, fill_valid}, 32'd1);
        chk("fw.hit_fd", fill_data, 32'hB);
        chk("fw.hit_memreq", {31'd0, mem_req}, 32'd0);
`else
        chk("nf.fv", {31'd0, fill_valid}, 32'd0);
        chk_all("nf.drain0", 1'b0, 1'b1, 1'b1, 32'h300, 32'hA, 1'b0, 32'h55);
        cyc(0,0,0,0,               1,0);
        chk_all("nf.drain0b", 1'b0, 1'b1, 1'b1, 32'h300, 32'hA, 1'b0, 32'h55);
        cyc(0,0,0,0,               1,0);
        chk_all("nf.drain1", 1'b0, 1'b1, 1'b1, 32'h300, 32'hB, 1'b0, 32'h55);
        cyc(0,0,0,0,               1,32'h77);
        chk_all("nf.read", 1'b0, 1'b1, 1'b0, 32'h300, 32'hB, 1'b0, 32'h55);
        cyc(0,0,0,0,               0,0);
        chk_all("nf.resp", 1'b0, 1'b0, 1'b0, 32'h300, 32'hB, 1'b1, 32'h77);
`endif

        // reset from an arbitrary state
        rst_n = 1'b0;
        #1;
        chk_all("rst2", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // reset while a read is outstanding with a store buffered
        cyc(1,0,32'h104,0,         0,0);
        cyc(1,1,32'h600,32'h66,    0,0);
        chk("rr.req", {31'd0, mem_req}, 32'd1);
        chk("rr.we", {31'd0, mem_we}, 32'd0);
        chk("rr.addr", mem_addr, 32'h104);
        cyc(0,0,0,0,               0,0);
        chk("rr.req_before", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rr.req_async", {31'd0, mem_req}, 32'd0);
        chk("rr.addr_async", mem_addr, 32'h0);
        chk("rr.fv_async", {31'd0, fill_valid}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(0,0,0,0,           1,32'hBAD0BAD0);
            chk($sformatf("rr.post%0d.mem_req", i), {31'd0, mem_req}, 32'd0);
            chk($sformatf("rr.post%0d.fill_valid", i), {31'd0, fill_valid}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_fill_ctrl.md
MEM_FILL_CTRL -- requirements
Module: mem_fill_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, address width; DATA_WIDTH, default 32, data width; WB_DEPTH, default 4, write-buffer entries (power of 2, at least 2).
REQ-002 SHALL have ports (clock and reset first):
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  cache request: read miss or store.
- req_write  input  1  1 = store, 0 = read miss.
- req_addr  input  ADDR_WIDTH  byte address; bits [1:0] ignored.
- req_wdata  input  DATA_WIDTH  store word.
- req_ready  output  1  request accepted this cycle when high with req_valid.
- fill_valid  output  1  one-cycle pulse: fill_data valid for the cache line refill.
- fill_data  output  DATA_WIDTH  refill word.
- mem_req  output  1  main-memory transfer request.
- mem_we  output  1  1 = write transfer.
- mem_addr  output  ADDR_WIDTH  word-aligned transfer address.
- mem_wdata  output  DATA_WIDTH  write data.
- mem_ready  input  1  memory completes the transfer this cycle.
- mem_rdata  input  DATA_WIDTH  read data, valid with mem_ready on reads.

Function
REQ-003 SHALL use a posted write buffer (FIFO, WB_DEPTH entries of {word address, data}) for all stores.
REQ-004 SHALL drive req_ready as follows: for stores, high when the buffer is not full; for reads, high only in state IDLE. A full buffer refuses enqueue even if a dequeue occurs the same cycle.
REQ-005 SHALL implement FSM states IDLE, DRAIN, READ, RESP.
REQ-006 IDLE: an accepted read with an empty buffer goes to READ. An accepted read with a non-empty buffer latches the address and goes to DRAIN. With no read pending and a non-empty buffer, the FSM goes to DRAIN.
REQ-007 DRAIN: mem_req=1, mem_we=1, address and data from the buffer head. On mem_ready, pop the head. When the last entry pops: go to READ if a read is latched, else IDLE.
REQ-008 READ: mem_req=1, mem_we=0, mem_addr = latched address with [1:0]=0. On mem_ready, capture mem_rdata and go to RESP.
REQ-009 RESP: fill_valid=1 for exactly one cycle with the captured data, then return to IDLE.
REQ-010 Once mem_req is asserted, mem_addr, mem_we and mem_wdata SHALL hold stable until the cycle mem_ready is sampled high.
REQ-011 mem_req SHALL be registered, asserted the cycle after entering DRAIN or READ; no combinational path from req_* to mem_*.
REQ-012 Read latency with an empty buffer: mem_req rises the cycle after accept; fill_valid occurs the cycle after mem_ready.
REQ-013 Stores accepted during DRAIN SHALL join the tail and be drained before the latched read issues (strict ordering).
REQ-014 FIFO pointers SHALL wrap modulo WB_DEPTH; occupancy SHALL be tracked as a count, width clog2(WB_DEPTH)+1.
REQ-015 Simultaneous enqueue and dequeue when not full SHALL leave the count unchanged and accept both.

Reset
REQ-016 rst_n low SHALL immediately force: state IDLE, buffer empty, latched read cleared, mem_req=0, mem_we=0, fill_valid=0, fill_data=0, mem_addr=0, mem_wdata=0. req_ready follows REQ-004 (stores ready, reads ready).
REQ-017 Reset mid-transfer SHALL abandon the transfer and discard all buffered stores; no pulse is emitted after release.

Configuration
REQ-018 Macro WB_FWD_EN defined: a read in IDLE whose word address matches a buffered entry returns the youngest matching data. The FSM goes directly to RESP, with fill_valid the cycle after accept, no memory access and no drain.
REQ-019 Macro WB_FWD_EN undefined: no address comparison logic; all reads follow REQ-006.

Structure
REQ-020 Package mem_pkg SHALL hold the FSM state enum, the wb_entry_t packed struct {addr, data}, and the default WB_DEPTH constant.
REQ-021 The FIFO SHALL be the sub-module wb_fifo (push, pop, head, full, empty, count). Forwarding match logic SHALL stay in mem_fill_ctrl.

Verification
REQ-022 Read miss 0x0000_0104, buffer empty, mem_ready after 3 cycles -> mem_addr=0x104, mem_we=0; fill_valid pulses once with mem_rdata=0xDEAD_BEEF.
REQ-023 Five back-to-back stores, WB_DEPTH=4, mem_ready held low -> first four accepted, fifth sees req_ready=0 until the first pop.
REQ-024 Store 0x200=0x11, then read 0x204 -> memory write to 0x200 completes before the memory read of 0x204 issues.
REQ-025 WB_FWD_EN defined: stores 0x300=0xA, 0x300=0xB, then read 0x302 -> fill_data=0xB the next cycle, mem_req low for the read.
REQ-026 rst_n pulsed low during READ with mem_req=1 -> mem_req=0 the same cycle, count=0, no fill_valid after release.
